hazard_stall_ctrl: RTL and testbench

- Stall/flush controller for the 5-stage pipeline, complementing the forwarding unit.
- Forwarding resolves hazards by bypassing values. This block handles the cases bypassing cannot resolve:
  - load-use hazards (stall one cycle);
  - multicycle mult/div in X (start the multdiv unit, freeze the front end, bubble X/M until the result is ready);
  - taken branches/jumps (squash the wrong-path instruction).
- Sits beside the bypass unit; drives PC/latch enables and nop-insert selects.

---
 rtl/hazard_stall_ctrl_if.sv | 32 +++
 rtl/hazard_stall_ctrl.sv | 146 ++++++++++++++
 tb/tb_hazard_stall_ctrl.sv | 315 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/hazard_stall_ctrl_if.sv
// Signal bundle between the pipeline and the hazard stall/flush controller.
interface hazard_stall_ctrl_if #(
    parameter int STALL_CNT_W = 32
);
    logic [31:0]            fd_ir;
    logic [31:0]            dx_ir;
    logic                   branch_taken;
    logic                   multdiv_ready;
    logic                   multdiv_exception;
    logic                   ctrl_mult;
    logic                   ctrl_div;
    logic                   freeze_front;
    logic                   bubble_dx;
    logic                   flush_fd;
    logic                   xm_bubble;
    logic                   md_result_sel;
    logic                   md_exception;
    logic                   md_busy;
    logic [STALL_CNT_W-1:0] stall_cycles;

    modport master (
        output fd_ir, dx_ir, branch_taken, multdiv_ready, multdiv_exception,
        input  ctrl_mult, ctrl_div, freeze_front, bubble_dx, flush_fd, xm_bubble,
               md_result_sel, md_exception, md_busy, stall_cycles
    );

    modport slave (
        input  fd_ir, dx_ir, branch_taken, multdiv_ready, multdiv_exception,
        output ctrl_mult, ctrl_div, freeze_front, bubble_dx, flush_fd, xm_bubble,
               md_result_sel, md_exception, md_busy, stall_cycles
    );
endinterface

// File: rtl/hazard_stall_ctrl.sv
// Stall/flush controller: load-use stalls, multicycle mult/div sequencing with
// timeout, and wrong-path squash on taken branches.
module hazard_stall_ctrl #(
    parameter int MD_TIMEOUT  = 64,
    parameter int STALL_CNT_W = 32
) (
    input  logic              clock,
    input  logic              reset,
    hazard_stall_ctrl_if.slave bus
);
    localparam int CNT_W = (MD_TIMEOUT > 1) ? $clog2(MD_TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MD_TIMEOUT - 1);

    localparam logic [4:0] OP_RTYPE = 5'b00000;
    localparam logic [4:0] OP_LW    = 5'b01000;
    localparam logic [4:0] OP_BNE   = 5'b00010;
    localparam logic [4:0] OP_BLT   = 5'b00110;
    localparam logic [4:0] OP_JR    = 5'b00100;
    localparam logic [4:0] OP_BEX   = 5'b10110;
    localparam logic [4:0] ALU_MUL  = 5'b00110;
    localparam logic [4:0] ALU_DIV  = 5'b00111;

    typedef enum logic {
        S_IDLE,
        S_WAIT
    } state_e;

    state_e                 state_q, state_d;
    logic [CNT_W-1:0]       mdCnt_q, mdCnt_d;
    logic [STALL_CNT_W-1:0] stallCnt_q, stallCnt_d;

    logic [4:0] fdOp, dxOp, fdRs, dxRd, fdSrc2;
    logic       fdHasSrc2, dxIsLw, dxIsMul, dxIsDiv, loadUse;

    logic startMult, startDiv, freeze, bubbleDx, flushFd, xmBubble, resultSel, mdExc;

    assign fdOp    = bus.fd_ir[31:27];
    assign fdRs    = bus.fd_ir[21:17];
    assign dxOp    = bus.dx_ir[31:27];
    assign dxRd    = bus.dx_ir[26:22];
    assign dxIsLw  = (dxOp == OP_LW);
    assign dxIsMul = (dxOp == OP_RTYPE) && (bus.dx_ir[6:2] == ALU_MUL);
    assign dxIsDiv = (dxOp == OP_RTYPE) && (bus.dx_ir[6:2] == ALU_DIV);

    // sw's data register is deliberately absent: the W->M bypass covers it.
    always_comb begin
        fdHasSrc2 = 1'b0;
        fdSrc2    = 5'd0;
        case (fdOp)
            OP_RTYPE: begin
                fdHasSrc2 = 1'b1;
                fdSrc2    = bus.fd_ir[16:12];
            end
            OP_BNE, OP_BLT, OP_JR: begin
                fdHasSrc2 = 1'b1;
                fdSrc2    = bus.fd_ir[26:22];
            end
            OP_BEX: begin
                fdHasSrc2 = 1'b1;
                fdSrc2    = 5'd30;
            end
            default: ;
        endcase
    end

    assign loadUse = dxIsLw && (dxRd != 5'd0) &&
                     ((fdRs == dxRd) || (fdHasSrc2 && (fdSrc2 == dxRd)));

    always_comb begin
        state_d   = state_q;
        mdCnt_d   = mdCnt_q;
        startMult = 1'b0;
        startDiv  = 1'b0;
        freeze    = 1'b0;
        bubbleDx  = 1'b0;
        flushFd   = 1'b0;
        xmBubble  = 1'b0;
        resultSel = 1'b0;
        mdExc     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if ((dxIsMul || dxIsDiv) && !bus.branch_taken) begin
                    startMult = dxIsMul;
                    startDiv  = dxIsDiv;
                    freeze    = 1'b1;
                    xmBubble  = 1'b1;
                    mdCnt_d   = '0;
                    state_d   = S_WAIT;
                end else if (bus.branch_taken) begin
                    flushFd  = 1'b1;
                    bubbleDx = 1'b1;
                end else if (loadUse) begin
                    freeze   = 1'b1;
                    bubbleDx = 1'b1;
                end
            end
            S_WAIT: begin
                if (bus.multdiv_ready) begin
                    resultSel = 1'b1;
                    mdExc     = bus.multdiv_exception;
                    state_d   = S_IDLE;
                end else if (mdCnt_q == CNT_LAST) begin
                    resultSel = 1'b1;
                    mdExc     = 1'b1;
                    state_d   = S_IDLE;
                end else begin
                    freeze   = 1'b1;
                    xmBubble = 1'b1;
                    mdCnt_d  = mdCnt_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        stallCnt_d = stallCnt_q;
        if (freeze && (stallCnt_q != '1)) begin
            stallCnt_d = stallCnt_q + 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            mdCnt_q    <= '0;
            stallCnt_q <= '0;
        end else begin
            state_q    <= state_d;
            mdCnt_q    <= mdCnt_d;
            stallCnt_q <= stallCnt_d;
        end
    end

    // Combinational outputs are gated so everything reads zero while reset is held.
    assign bus.ctrl_mult     = reset & startMult;
    assign bus.ctrl_div      = reset & startDiv;
    assign bus.freeze_front  = reset & freeze;
    assign bus.bubble_dx     = reset & bubbleDx;
    assign bus.flush_fd      = reset & flushFd;
    assign bus.xm_bubble     = reset & xmBubble;
    assign bus.md_result_sel = reset & resultSel;
    assign bus.md_exception  = reset & mdExc;
    assign bus.md_busy       = reset & (state_q == S_WAIT);
    assign bus.stall_cycles  = stallCnt_q;
endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Self-checking bench for hazard_stall_ctrl: directed scenarios with literal
// expectations plus randomized traffic checked every cycle against a model.
module tb_hazard_stall_ctrl;
    localparam int MD_TIMEOUT  = 8;
    localparam int STALL_CNT_W = 8;
    localparam int STALL_MAX   = (1 << STALL_CNT_W) - 1;

    logic clock = 1'b0;
    logic reset = 1'b1;

    always #5 clock = ~clock;

    hazard_stall_ctrl_if #(.STALL_CNT_W(STALL_CNT_W)) bus ();

    hazard_stall_ctrl #(
        .MD_TIMEOUT (MD_TIMEOUT),
        .STALL_CNT_W(STALL_CNT_W)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus.slave)
    );

    int vectors     = 0;
    int miscompares = 0;

    bit mBusy  = 1'b0;
    int mAge   = 0;
    int mStall = 0;
    bit eMult, eDiv, eFreeze, eBubble, eFlush, eXm, eSel, eExc, eBusy;
    int eStall;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
        end
    endtask

    function automatic logic [31:0] rInstr(input logic [4:0] rd, input logic [4:0] rs,
                                           input logic [4:0] rt, input logic [4:0] aluOp);
        return {5'b00000, rd, rs, rt, 5'd0, aluOp, 2'b00};
    endfunction

    function automatic logic [31:0] iInstr(input logic [4:0] op, input logic [4:0] rd,
                                           input logic [4:0] rs, input logic [16:0] imm);
        return {op, rd, rs, imm};
    endfunction

    // Reference: outputs follow directly from the rule list, with the mult/div
    // wait tracked as the number of cycles elapsed since the start pulse.
    task automatic modelOutputs();
        logic [4:0] fOp, dOp, dRd;
        logic [4:0] srcs[$];
        bit lu, dMul, dDiv;
        {eMult, eDiv, eFreeze, eBubble, eFlush, eXm, eSel, eExc, eBusy} = '0;
        eStall = mStall;
        if (!reset) begin
            eStall = 0;
            return;
        end
        fOp  = bus.fd_ir[31:27];
        dOp  = bus.dx_ir[31:27];
        dRd  = bus.dx_ir[26:22];
        dMul = (dOp == 5'b00000) && (bus.dx_ir[6:2] == 5'b00110);
        dDiv = (dOp == 5'b00000) && (bus.dx_ir[6:2] == 5'b00111);
        srcs.push_back(bus.fd_ir[21:17]);
        if (fOp == 5'b00000) srcs.push_back(bus.fd_ir[16:12]);
        if (fOp == 5'b00010 || fOp == 5'b00110 || fOp == 5'b00100) srcs.push_back(bus.fd_ir[26:22]);
        if (fOp == 5'b10110) srcs.push_back(5'd30);
        lu = 1'b0;
        if (dOp == 5'b01000 && dRd != 5'd0) begin
            foreach (srcs[k]) if (srcs[k] == dRd) lu = 1'b1;
        end
        if (mBusy) begin
            eBusy = 1'b1;
            if (bus.multdiv_ready) begin
                eSel = 1'b1;
                eExc = bus.multdiv_exception;
            end else if (mAge == MD_TIMEOUT) begin
                eSel = 1'b1;
                eExc = 1'b1;
            end else begin
                eFreeze = 1'b1;
                eXm     = 1'b1;
            end
        end else if ((dMul || dDiv) && !bus.branch_taken) begin
            eMult   = dMul;
            eDiv    = dDiv;
            eFreeze = 1'b1;
            eXm     = 1'b1;
        end else if (bus.branch_taken) begin
            eFlush  = 1'b1;
            eBubble = 1'b1;
        end else if (lu) begin
            eFreeze = 1'b1;
            eBubble = 1'b1;
        end
    endtask

    task automatic modelAdvance();
        if (!reset) begin
            mBusy  = 1'b0;
            mAge   = 0;
            mStall = 0;
            return;
        end
        if (eFreeze && mStall < STALL_MAX) mStall++;
        if (mBusy) begin
            if (eSel) mBusy = 1'b0;
            else      mAge++;
        end else if (eMult || eDiv) begin
            mBusy = 1'b1;
            mAge  = 1;
        end
    endtask

    // Single compare process: check every output mid-cycle, then step the model.
    always @(negedge clock) begin
        modelOutputs();
        checkOutput("ctrl_mult",     32'(bus.ctrl_mult),     32'(eMult));
        checkOutput("ctrl_div",      32'(bus.ctrl_div),      32'(eDiv));
        checkOutput("freeze_front",  32'(bus.freeze_front),  32'(eFreeze));
        checkOutput("bubble_dx",     32'(bus.bubble_dx),     32'(eBubble));
        checkOutput("flush_fd",      32'(bus.flush_fd),      32'(eFlush));
        checkOutput("xm_bubble",     32'(bus.xm_bubble),     32'(eXm));
        checkOutput("md_result_sel", 32'(bus.md_result_sel), 32'(eSel));
        checkOutput("md_exception",  32'(bus.md_exception),  32'(eExc));
        checkOutput("md_busy",       32'(bus.md_busy),       32'(eBusy));
        checkOutput("stall_cycles",  32'(bus.stall_cycles),  32'(eStall));
        modelAdvance();
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic applyStimulus(input logic [31:0] fd, input logic [31:0] dx,
                                 input logic br, input logic rdy, input logic exc);
        bus.fd_ir             = fd;
        bus.dx_ir             = dx;
        bus.branch_taken      = br;
        bus.multdiv_ready     = rdy;
        bus.multdiv_exception = exc;
    endtask

    task automatic doReset();
        reset = 1'b0;
        applyStimulus(32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
        tick();
        tick();
        reset = 1'b1;
    endtask

    function automatic logic [4:0] randReg();
        int r = $urandom_range(0, 8);
        return (r == 8) ? 5'd30 : 5'(r);
    endfunction

    function automatic logic [31:0] randInstr();
        case ($urandom_range(0, 9))
            0: return rInstr(randReg(), randReg(), randReg(), 5'b00000);
            1: return rInstr(randReg(), randReg(), randReg(), 5'b00110);
            2: return rInstr(randReg(), randReg(), randReg(), 5'b00111);
            3: return iInstr(5'b01000, randReg(), randReg(), 17'($urandom));
            4: return iInstr(5'b00111, randReg(), randReg(), 17'($urandom));
            5: return iInstr(5'b00010, randReg(), randReg(), 17'($urandom));
            6: return iInstr(5'b00110, randReg(), randReg(), 17'($urandom));
            7: return iInstr(5'b00100, randReg(), 5'd0, 17'd0);
            8: return iInstr(5'b10110, 5'd0, 5'd0, 17'($urandom));
            default: return 32'($urandom);
        endcase
    endfunction

    task automatic randomPhase(input int cycles, input bit allowReset);
        for (int n = 0; n < cycles; n++) begin
            reset = (allowReset && $urandom_range(0, 199) == 0) ? 1'b0 : 1'b1;
            applyStimulus(randInstr(), randInstr(), 1'($urandom_range(0, 5) == 0),
                          mBusy ? 1'($urandom_range(0, 9) == 0) : 1'($urandom_range(0, 19) == 0),
                          1'($urandom_range(0, 1)));
            tick();
        end
    endtask

    initial begin
        logic [31:0] lwR5, addDep, mulI, divI;
        lwR5   = iInstr(5'b01000, 5'd5, 5'd1, 17'd0);
        addDep = rInstr(5'd2, 5'd5, 5'd3, 5'b00000);
        mulI   = rInstr(5'd4, 5'd2, 5'd3, 5'b00110);
        divI   = rInstr(5'd4, 5'd2, 5'd3, 5'b00111);

        applyStimulus(32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
        #1;
        doReset();

        $display("[TB] load-use stall");
        applyStimulus(addDep, lwR5, 1'b0, 1'b0, 1'b0);
        @(negedge clock);
        checkOutput("lu_freeze", 32'(bus.freeze_front), 32'd1);
        checkOutput("lu_bubble", 32'(bus.bubble_dx), 32'd1);
        tick();
        applyStimulus(addDep, 32'd0, 1'b0, 1'b0, 1'b0);
        @(negedge clock);
        checkOutput("lu_release_freeze", 32'(bus.freeze_front), 32'd0);
        checkOutput("lu_release_bubble", 32'(bus.bubble_dx), 32'd0);
        checkOutput("lu_stall_count", 32'(bus.stall_cycles), 32'd1);
        tick();

        applyStimulus(iInstr(5'b00111, 5'd5, 5'd2, 17'd4), lwR5, 1'b0, 1'b0, 1'b0);
        @(negedge clock);
        checkOutput("sw_data_no_stall", 32'(bus.freeze_front), 32'd0);
        tick();
        applyStimulus(rInstr(5'd2, 5'd0, 5'd3, 5'b00000), iInstr(5'b01000, 5'd0, 5'd1, 17'd0),
                      1'b0, 1'b0, 1'b0);
        @(negedge clock);
        checkOutput("r0_no_stall", 32'(bus.freeze_front), 32'd0);
        tick();

        $display("[TB] mul with ready after 4 cycles");
        doReset();
        for (int i = 0; i < 4; i++) begin
            applyStimulus(32'd0, mulI, 1'b0, 1'b0, 1'b0);
            @(negedge clock);
            checkOutput("mul_start_pulse", 32'(bus.ctrl_mult), (i == 0) ? 32'd1 : 32'd0);
            checkOutput("mul_freeze", 32'(bus.freeze_front), 32'd1);
            checkOutput("mul_xm_bubble", 32'(bus.xm_bubble), 32'd1);
            tick();
        end
        applyStimulus(32'd0, mulI, 1'b0, 1'b1, 1'b0);
        @(negedge clock);
        checkOutput("mul_result_sel", 32'(bus.md_result_sel), 32'd1);
        checkOutput("mul_release_freeze", 32'(bus.freeze_front), 32'd0);
        checkOutput("mul_no_exception", 32'(bus.md_exception), 32'd0);
        tick();
        applyStimulus(32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
        @(negedge clock);
        checkOutput("mul_busy_cleared", 32'(bus.md_busy), 32'd0);
        checkOutput("mul_stall_count", 32'(bus.stall_cycles), 32'd4);
        tick();

        $display("[TB] div timeout");
        doReset();
        for (int i = 0; i < 8; i++) begin
            applyStimulus(32'd0, divI, 1'b0, 1'b0, 1'b0);
            @(negedge clock);
            checkOutput("div_start_pulse", 32'(bus.ctrl_div), (i == 0) ? 32'd1 : 32'd0);
            checkOutput("div_freeze", 32'(bus.freeze_front), 32'd1);
            tick();
        end
        applyStimulus(32'd0, divI, 1'b0, 1'b0, 1'b0);
        @(negedge clock);
        checkOutput("timeout_result_sel", 32'(bus.md_result_sel), 32'd1);
        checkOutput("timeout_exception", 32'(bus.md_exception), 32'd1);
        checkOutput("timeout_freeze", 32'(bus.freeze_front), 32'd0);
        checkOutput("timeout_busy", 32'(bus.md_busy), 32'd1);
        tick();
        applyStimulus(32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
        @(negedge clock);
        checkOutput("timeout_busy_fall", 32'(bus.md_busy), 32'd0);
        checkOutput("timeout_stall_count", 32'(bus.stall_cycles), 32'd8);
        tick();

        $display("[TB] branch flush over load-use");
        doReset();
        applyStimulus(addDep, lwR5, 1'b1, 1'b0, 1'b0);
        @(negedge clock);
        checkOutput("br_flush", 32'(bus.flush_fd), 32'd1);
        checkOutput("br_bubble", 32'(bus.bubble_dx), 32'd1);
        checkOutput("br_no_freeze", 32'(bus.freeze_front), 32'd0);
        tick();
        applyStimulus(32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
        @(negedge clock);
        checkOutput("br_no_count", 32'(bus.stall_cycles), 32'd0);
        tick();

        $display("[TB] reset during mult/div wait");
        doReset();
        applyStimulus(32'd0, mulI, 1'b0, 1'b0, 1'b0);
        tick();
        tick();
        checkOutput("pre_reset_busy", 32'(bus.md_busy), 32'd1);
        checkOutput("pre_reset_stall", 32'(bus.stall_cycles), 32'd2);
        reset = 1'b0;
        #1;
        checkOutput("rst_freeze", 32'(bus.freeze_front), 32'd0);
        checkOutput("rst_xm_bubble", 32'(bus.xm_bubble), 32'd0);
        checkOutput("rst_ctrl_mult", 32'(bus.ctrl_mult), 32'd0);
        checkOutput("rst_busy", 32'(bus.md_busy), 32'd0);
        checkOutput("rst_stall", 32'(bus.stall_cycles), 32'd0);
        tick();
        reset = 1'b1;
        applyStimulus(32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
        @(negedge clock);
        checkOutput("post_rst_idle", 32'(bus.md_busy), 32'd0);
        checkOutput("post_rst_freeze", 32'(bus.freeze_front), 32'd0);
        tick();
        @(negedge clock);
        checkOutput("post_rst_still_idle", 32'(bus.md_busy), 32'd0);
        tick();

        $display("[TB] random traffic");
        randomPhase(1500, 1'b1);
        reset = 1'b1;
        randomPhase(2000, 1'b0);
        applyStimulus(32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
        @(negedge clock);
        checkOutput("stall_saturated", 32'(bus.stall_cycles), 32'(STALL_MAX));
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
